gray_floor_encoder: RTL and testbench

Position encoder for the elevator car: takes a target floor as a BCD digit and walks an internal floor position toward it one floor per step period, publishing the position as a registered 4-bit Gray code. Each update changes exactly one output bit. It is the producing end of the Gray floor bus: it feeds the Gray-to-BCD decode path that drives the 7-segment floor display, and it stands in for the shaft position sensor in simulation and bring-up.

---
 rtl/gray_floor_encoder_pkg.sv | 15 +
 rtl/gray_floor_encoder_if.sv | 24 ++
 rtl/gray_floor_encoder_step_timer.sv | 25 ++
 rtl/gray_floor_encoder.sv | 103 ++++++++++
 tb/tb_gray_floor_encoder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_floor_encoder_pkg.sv
// Shared types and helpers for the Gray floor position encoder.
package floor_enc_pkg;

    localparam int FLOOR_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        MOVE = 1'b1
    } state_e;

    function automatic logic [FLOOR_W-1:0] bin2gray(input logic [FLOOR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_floor_encoder_if.sv
// Request/position bus between a floor requester and the Gray floor encoder.
interface gray_floor_if;
    import floor_enc_pkg::*;

    logic [FLOOR_W-1:0] bcd_in;
    logic               req_valid;
    logic               req_ready;
    logic [FLOOR_W-1:0] gray_out;
    logic               moving;
    logic               dir_up;
    logic               arrived;
    logic               err;

    modport master (
        output bcd_in, req_valid,
        input  req_ready, gray_out, moving, dir_up, arrived, err
    );

    modport slave (
        input  bcd_in, req_valid,
        output req_ready, gray_out, moving, dir_up, arrived, err
    );

endinterface

// File: rtl/gray_floor_encoder_step_timer.sv
// Step period counter: counts 0..STEP_CYCLES-1 while enabled, tc on the last count.
module step_timer #(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (clr)    cnt <= '0;
        else if (en)     cnt <= tc ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/gray_floor_encoder.sv
// Walks a floor position toward a BCD target one floor per step, publishing Gray code.
// Optional GRAY_FLOOR_ENC_ABORT_EN adds an abort input that cancels a move in place.
module gray_floor_encoder
    import floor_enc_pkg::*;
#(
    parameter int FLOORS      = 10,
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef GRAY_FLOOR_ENC_ABORT_EN
    input  logic abort,
`endif
    gray_floor_if.slave bus
);

    state_e             state, state_nxt;
    logic [FLOOR_W-1:0] pos, pos_nxt;
    logic [FLOOR_W-1:0] target, target_nxt;
    logic [FLOOR_W-1:0] gray_q;
    logic               dir_up, dir_nxt;
    logic               arrived_q, arrived_nxt;
    logic               err_q, err_nxt;
    logic               tmr_clr, tmr_tc;

    step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (state == MOVE),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_nxt   = state;
        pos_nxt     = pos;
        target_nxt  = target;
        dir_nxt     = dir_up;
        arrived_nxt = 1'b0;
        err_nxt     = 1'b0;
        tmr_clr     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    // Anything past the top floor, including non-BCD codes, is rejected.
                    if (bus.bcd_in >= FLOOR_W'(FLOORS)) begin
                        err_nxt = 1'b1;
                    end else if (bus.bcd_in == pos) begin
                        arrived_nxt = 1'b1;
                    end else begin
                        target_nxt = bus.bcd_in;
                        dir_nxt    = (bus.bcd_in > pos);
                        tmr_clr    = 1'b1;
                        state_nxt  = MOVE;
                    end
                end
            end
            MOVE: begin
`ifdef GRAY_FLOOR_ENC_ABORT_EN
                if (abort) begin
                    state_nxt = IDLE;
                end else
`endif
                if (tmr_tc) begin
                    pos_nxt = dir_up ? pos + FLOOR_W'(1) : pos - FLOOR_W'(1);
                    if (pos_nxt == target) begin
                        state_nxt   = IDLE;
                        arrived_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pos       <= '0;
            target    <= '0;
            gray_q    <= '0;
            dir_up    <= 1'b1;
            arrived_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            pos       <= pos_nxt;
            target    <= target_nxt;
            gray_q    <= bin2gray(pos_nxt);
            dir_up    <= dir_nxt;
            arrived_q <= arrived_nxt;
            err_q     <= err_nxt;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.moving    = (state == MOVE);
    assign bus.gray_out  = gray_q;
    assign bus.dir_up    = dir_up;
    assign bus.arrived   = arrived_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_gray_floor_encoder.sv
// Scoreboard bench for gray_floor_encoder: expected Gray steps and pulses are queued per request.
module tb_gray_floor_encoder;

    localparam int FLOORS = 10;
    localparam int S      = 4;
    localparam int K_GRAY = 0, K_ARR = 1, K_ERR = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef GRAY_FLOOR_ENC_ABORT_EN
    logic abort = 1'b0;
`endif

    gray_floor_if bus_if ();

    gray_floor_encoder #(.FLOORS(FLOORS), .STEP_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef GRAY_FLOOR_ENC_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         mov_cnt = 0;
    int         tb_pos = 0;
    logic [3:0] prev_gray = 4'h0;
    ev_t        q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] g(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic expect_evt(input int kind, input logic [3:0] val);
        ev_t e;
        if (q.size() == 0) begin
            chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            chk("event_cycle", 32'(cyc), 32'(e.cyc));
            if (kind == K_GRAY) chk("gray_value", {28'h0, val}, {28'h0, e.val});
        end
    endtask

    // Monitor: every Gray change or pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.gray_out != prev_gray) begin
                chk("gray_hamming", 32'($countones(bus_if.gray_out ^ prev_gray)), 32'd1);
                expect_evt(K_GRAY, bus_if.gray_out);
            end
            if (bus_if.arrived) expect_evt(K_ARR, 4'h0);
            if (bus_if.err)     expect_evt(K_ERR, 4'h0);
            if (bus_if.moving)  mov_cnt++;
        end
        prev_gray = bus_if.gray_out;
    end

    // Called #1 after a rising edge; request is accepted on the next edge.
    task automatic do_req(input int t);
        int  k, n;
        bit  up;
        k = cyc + 1;
        chk("req_ready_before_req", {31'h0, bus_if.req_ready}, 32'd1);
        bus_if.bcd_in    = 4'(t);
        bus_if.req_valid = 1'b1;
        mov_cnt = 0;
        if (t >= FLOORS) begin
            q.push_back('{K_ERR, k, 4'h0});
            n = 0;
        end else if (t == tb_pos) begin
            q.push_back('{K_ARR, k, 4'h0});
            n = 0;
        end else begin
            up = (t > tb_pos);
            n  = up ? t - tb_pos : tb_pos - t;
            for (int i = 1; i <= n; i++)
                q.push_back('{K_GRAY, k + i * S, g(up ? tb_pos + i : tb_pos - i)});
            q.push_back('{K_ARR, k + n * S, 4'h0});
        end
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        chk("moving_after_req", {31'h0, bus_if.moving}, {31'h0, n > 0});
        if (n > 0) begin
            chk("dir_up", {31'h0, bus_if.dir_up}, {31'h0, up});
            tb_pos = t;
        end
    endtask

    task automatic req_ignored(input int t);
        chk("req_ready_in_move", {31'h0, bus_if.req_ready}, 32'd0);
        bus_if.bcd_in    = 4'(t);
        bus_if.req_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #1;
            if (q.size() == 0) done = 1;
        end
        chk("wait_idle_timeout", {31'h0, done}, 32'd1);
        q.delete();
    endtask

    task automatic wait_gray(input logic [3:0] v, input int budget);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk); #1;
            if (bus_if.gray_out == v) hit = 1;
        end
        chk("wait_gray_timeout", {31'h0, hit}, 32'd1);
    endtask

    initial begin
        bus_if.bcd_in    = 4'h0;
        bus_if.req_valid = 1'b0;
        #12;
        chk("rst_req_ready", {31'h0, bus_if.req_ready}, 32'd1);
        chk("rst_gray", {28'h0, bus_if.gray_out}, 32'h0);
        chk("rst_moving", {31'h0, bus_if.moving}, 32'd0);
        chk("rst_dir_up", {31'h0, bus_if.dir_up}, 32'd1);
        chk("rst_arrived", {31'h0, bus_if.arrived}, 32'd0);
        chk("rst_err", {31'h0, bus_if.err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 0 -> 3: Gray 0001, 0011, 0010, moving for 3*S cycles.
        do_req(3);
        wait_idle(200);
        chk("move3_moving_cycles", 32'(mov_cnt), 32'(3 * S));
        chk("move3_final_gray", {28'h0, bus_if.gray_out}, 32'b0010);

        // 3 -> 9, then 9 -> 0 walking down.
        do_req(9);
        wait_idle(200);
        chk("floor9_gray", {28'h0, bus_if.gray_out}, 32'b1101);
        do_req(0);
        wait_idle(200);
        chk("floor0_gray", {28'h0, bus_if.gray_out}, 32'b0000);
        chk("down_dir_held", {31'h0, bus_if.dir_up}, 32'd0);

        // Out-of-range targets.
        do_req(11);
        wait_idle(20);
        do_req(10);
        wait_idle(20);
        chk("err_no_gray_change", {28'h0, bus_if.gray_out}, 32'h0);

        // Same-floor request.
        do_req(5);
        wait_idle(200);
        chk("move5_moving_cycles", 32'(mov_cnt), 32'(5 * S));
        do_req(5);
        wait_idle(20);
        chk("same_floor_no_move", 32'(mov_cnt), 32'd0);

        // 5 -> 8 with a request ignored mid-move, then 8 -> 1 back-to-back.
        do_req(8);
        repeat (3) begin @(posedge clk); #1; end
        req_ignored(2);
        begin
            bit hit = 0;
            for (int i = 0; i < 100 && !hit; i++) begin
                if (bus_if.arrived) hit = 1;
                else begin @(posedge clk); #1; end
            end
            chk("arrive8_timeout", {31'h0, hit}, 32'd1);
        end
        chk("b2b_req_ready", {31'h0, bus_if.req_ready}, 32'd1);
        chk("b2b_gray8", {28'h0, bus_if.gray_out}, 32'b1100);
        do_req(1);
        wait_idle(200);
        chk("floor1_gray", {28'h0, bus_if.gray_out}, 32'b0001);

        // Reset while walking 2 -> 7, caught at floor 4.
        do_req(2);
        wait_idle(200);
        do_req(7);
        wait_gray(4'b0110, 100);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_gray", {28'h0, bus_if.gray_out}, 32'h0);
        chk("midrst_moving", {31'h0, bus_if.moving}, 32'd0);
        chk("midrst_req_ready", {31'h0, bus_if.req_ready}, 32'd1);
        tb_pos = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("postrst_req_ready", {31'h0, bus_if.req_ready}, 32'd1);
        chk("postrst_dir_up", {31'h0, bus_if.dir_up}, 32'd1);

`ifdef GRAY_FLOOR_ENC_ABORT_EN
        do_req(2);
        wait_idle(200);
        do_req(7);
        wait_gray(4'b0110, 100);
        abort = 1'b1;
        q.delete();
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_moving", {31'h0, bus_if.moving}, 32'd0);
        chk("abort_req_ready", {31'h0, bus_if.req_ready}, 32'd1);
        repeat (3 * S) begin @(posedge clk); #1; end
        chk("abort_gray_held", {28'h0, bus_if.gray_out}, 32'b0110);
        tb_pos = 4;
`endif

        repeat (4) begin @(posedge clk); #1; end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
